// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: instruction-class enum, opcodes, field widths.
// Latency: none (package only).
// Backpressure: not applicable.
package mips_pkg;

    // Instruction class presented on the kind port; codes 11-15 are illegal.
    typedef enum logic [3:0] {
        KIND_R    = 4'd0,
        KIND_ADDI = 4'd1,
        KIND_ORI  = 4'd2,
        KIND_ANDI = 4'd3,
        KIND_LUI  = 4'd4,
        KIND_LW   = 4'd5,
        KIND_SW   = 4'd6,
        KIND_BEQ  = 4'd7,
        KIND_BNE  = 4'd8,
        KIND_J    = 4'd9,
        KIND_JAL  = 4'd10
    } kind_e;

    // Primary opcodes, also consumed by the control decoder.
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0d;
    localparam logic [5:0] OP_ANDI = 6'h0c;
    localparam logic [5:0] OP_LUI  = 6'h0f;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;

    // Instruction format field widths.
    localparam int OP_W     = 6;
    localparam int REG_W    = 5;
    localparam int SHAMT_W  = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;
    localparam int TARGET_W = 26;

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational MIPS word assembly from class + fields; optional branch resolve (BRANCH_RESOLVE_EN).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller owns all handshaking.
module mips_instr_pack
    import mips_pkg::*;
(
    input  logic [3:0]          kind,
    input  logic [REG_W-1:0]    rs,
    input  logic [REG_W-1:0]    rt,
    input  logic [REG_W-1:0]    rd,
    input  logic [SHAMT_W-1:0]  shamt,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic [IMM_W-1:0]    imm,
    input  logic [TARGET_W-1:0] target,
    input  logic [TARGET_W-1:0] pc,        // word address of the slot being written (byte addr [27:2])
    output logic [31:0]         word,
    output logic                illegal,
    output logic                rangeErr
);

    logic [OP_W-1:0]  opcode;
    logic [REG_W-1:0] rsSel;
    logic [IMM_W-1:0] immSel;
    logic             isR;
    logic             isJump;

`ifdef BRANCH_RESOLVE_EN
    // Offset is relative to the slot after the branch; it fits when bits [25:15] are a pure sign extension.
    logic [TARGET_W-1:0] branchDelta;
    logic                branchFits;
    assign branchDelta = target - (pc + TARGET_W'(1));
    assign branchFits  = (branchDelta[25:15] == '0) || (branchDelta[25:15] == '1);
`else
    logic unusedPc;
    assign unusedPc = ^pc;
`endif

    // Select opcode and format per class, then assemble the word.
    always_comb begin
        opcode   = OP_R;
        rsSel    = rs;
        immSel   = imm;
        isR      = 1'b0;
        isJump   = 1'b0;
        illegal  = 1'b0;
        rangeErr = 1'b0;
        case (kind)
            KIND_R:    isR = 1'b1;
            KIND_ADDI: opcode = OP_ADDI;
            KIND_ORI:  opcode = OP_ORI;
            KIND_ANDI: opcode = OP_ANDI;
            KIND_LUI: begin
                opcode = OP_LUI;
                rsSel  = '0;
            end
            KIND_LW:   opcode = OP_LW;
            KIND_SW:   opcode = OP_SW;
            KIND_BEQ, KIND_BNE: begin
                opcode = (kind == KIND_BEQ) ? OP_BEQ : OP_BNE;
`ifdef BRANCH_RESOLVE_EN
                immSel   = branchDelta[IMM_W-1:0];
                rangeErr = !branchFits;
`endif
            end
            KIND_J: begin
                opcode = OP_J;
                isJump = 1'b1;
            end
            KIND_JAL: begin
                opcode = OP_JAL;
                isJump = 1'b1;
            end
            default:   illegal = 1'b1;
        endcase

        if (illegal)
            word = '0;
        else if (isR)
            word = {OP_R, rs, rt, rd, shamt, funct};
        else if (isJump)
            word = {opcode, target};
        else
            word = {opcode, rsSel, rt, immSel};
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Streams encoded MIPS words into instruction memory at BASE_ADDR upward; optional BRANCH_RESOLVE_EN.
// Latency: 1 cycle from input acceptance to wr_valid/wr_data.
// Backpressure: one-entry output register; in_ready drops while full or while the held word is stalled.
module mips_instr_encoder
    import mips_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter int          DEPTH     = 64,
    localparam int         CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    input  logic [3:0]          kind,
    input  logic [REG_W-1:0]    rs,
    input  logic [REG_W-1:0]    rt,
    input  logic [REG_W-1:0]    rd,
    input  logic [SHAMT_W-1:0]  shamt,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic [IMM_W-1:0]    imm,
    input  logic [TARGET_W-1:0] target,
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic [31:0]         wr_addr,
    output logic [31:0]         wr_data,
    output logic                done,
    output logic                err,
    output logic [CNT_W-1:0]    word_count
);

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_HOLD      = 2'd1,
        ST_FULL      = 2'd2,
        ST_FULL_IDLE = 2'd3
    } state_e;

    state_e           state;
    state_e           stateNext;
    logic [CNT_W-1:0] wordCount;
    logic [31:0]      addrReg;
    logic [31:0]      dataReg;
    logic             holdLast;
    logic             illegalDone;
    logic             errReg;

    logic [31:0]      pc;
    logic [31:0]      packWord;
    logic             packIllegal;
    logic             packRangeErr;
    logic             full;
    logic             reachesFull;
    logic             accept;
    logic             acceptLegal;
    logic             drain;

    assign pc          = BASE_ADDR + (32'(wordCount) << 2);
    assign full        = (wordCount == CNT_W'(DEPTH));
    assign reachesFull = (wordCount == CNT_W'(DEPTH - 1));
    assign wr_valid    = (state == ST_HOLD) || (state == ST_FULL);
    assign in_ready    = !reset && !full && (!wr_valid || wr_ready);
    assign accept      = in_valid && in_ready;
    assign acceptLegal = accept && !packIllegal;
    assign drain       = wr_valid && wr_ready;
    assign done        = !reset && ((drain && holdLast) || illegalDone);
    assign wr_addr     = addrReg;
    assign wr_data     = dataReg;
    assign err         = errReg;
    assign word_count  = wordCount;

    mips_instr_pack u_pack (
        .kind     (kind),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .shamt    (shamt),
        .funct    (funct),
        .imm      (imm),
        .target   (target),
        .pc       (pc[27:2]),
        .word     (packWord),
        .illegal  (packIllegal),
        .rangeErr (packRangeErr)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_EMPTY;
        else
            state <= stateNext;
    end

    // Next state: a legal accept refills the register (no bubble on simultaneous drain); full states exit only by reset.
    always_comb begin
        stateNext = state;
        case (state)
            ST_EMPTY, ST_HOLD: begin
                if (acceptLegal)
                    stateNext = reachesFull ? ST_FULL : ST_HOLD;
                else if (drain)
                    stateNext = ST_EMPTY;
            end
            ST_FULL:      if (drain) stateNext = ST_FULL_IDLE;
            ST_FULL_IDLE: stateNext = ST_FULL_IDLE;
            default:      stateNext = ST_EMPTY;
        endcase
    end

    // Output register, word counter, sticky error and the deferred done for illegal last inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            wordCount   <= '0;
            addrReg     <= BASE_ADDR;
            dataReg     <= '0;
            holdLast    <= 1'b0;
            illegalDone <= 1'b0;
            errReg      <= 1'b0;
        end else begin
            illegalDone <= accept && packIllegal && in_last;
            if (acceptLegal) begin
                wordCount <= wordCount + CNT_W'(1);
                addrReg   <= pc;
                dataReg   <= packWord;
                holdLast  <= in_last;
            end
            if ((accept && packIllegal) || (acceptLegal && packRangeErr))
                errReg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
module tb_mips_instr_encoder;

    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int          DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [3:0]  kind = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [5:0]  funct = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic [31:0] wr_addr, wr_data;
    logic        done, err;
    logic [6:0]  word_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        bit          last;
    } exp_t;

    mips_instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .kind(kind), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .target(target),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input int k, input int s, input int t, input int d, input int sh,
                             input int fn, input int im, input int tg, input bit last);
        in_valid = 1'b1;
        kind     = 4'(k);
        rs       = 5'(s);
        rt       = 5'(t);
        rd       = 5'(d);
        shamt    = 5'(sh);
        funct    = 6'(fn);
        imm      = 16'(im);
        target   = 26'(tg);
        in_last  = last;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        reset    = 1'b1;
        tick();
        tick();
        reset    = 1'b0;
    endtask

    // Reference encoder written from the instruction-format rules with plain arithmetic.
    function automatic void model_encode(input logic [3:0] k, input logic [4:0] s, input logic [4:0] t,
                                         input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
                                         input logic [15:0] im, input logic [25:0] tg, input logic [31:0] addr,
                                         output bit legal, output logic [31:0] w, output bit rerr);
        int opTab [11] = '{0, 8, 13, 12, 15, 35, 43, 4, 5, 2, 3};
        logic [31:0] op;
        logic [31:0] iv;
        int off;
        legal = (k <= 4'd10);
        rerr  = 1'b0;
        w     = '0;
        if (!legal) return;
        op = 32'(opTab[k]);
        if (k == 4'd0) begin
            w = (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | (32'(sh) << 6) | 32'(fn);
        end else if (k == 4'd9 || k == 4'd10) begin
            w = (op << 26) | 32'(tg);
        end else begin
            iv = 32'(im);
`ifdef BRANCH_RESOLVE_EN
            if (k == 4'd7 || k == 4'd8) begin
                off  = int'(tg) - (int'(addr / 4) % (1 << 26) + 1);
                iv   = 32'(off) & 32'h0000_FFFF;
                rerr = (off < -32768) || (off > 32767);
            end
`else
            off = int'(addr[1:0]);
`endif
            w = (op << 26) | ((k == 4'd4) ? 32'd0 : (32'(s) << 21)) | (32'(t) << 16) | iv;
        end
    endfunction

    task automatic test_reset();
        reset    = 1'b1;
        wr_ready = 1'b1;
        set_instr(0, 1, 2, 3, 0, 32, 0, 0, 1'b0);
        tick();
        tick();
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid); end
        checks++; if (wr_addr !== BASE) begin failures++; $display("FAIL reset_wr_addr got=%h exp=%h", wr_addr, BASE); end
        checks++; if (wr_data !== 32'h0) begin failures++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (word_count !== 7'd0) begin failures++; $display("FAIL reset_word_count got=%0d exp=0", word_count); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        in_valid = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic test_r_word();
        do_reset();
        wr_ready = 1'b1;
        set_instr(0, 1, 2, 3, 0, 32'h20, 0, 0, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL r_in_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (wr_valid !== 1'b1) begin failures++; $display("FAIL r_wr_valid got=%b exp=1", wr_valid); end
        checks++; if (wr_data !== 32'h00221820) begin failures++; $display("FAIL r_wr_data got=%h exp=00221820", wr_data); end
        checks++; if (wr_addr !== 32'h00400000) begin failures++; $display("FAIL r_wr_addr got=%h exp=00400000", wr_addr); end
        checks++; if (word_count !== 7'd1) begin failures++; $display("FAIL r_word_count got=%0d exp=1", word_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        wr_ready = 1'b1;
        set_instr(1, 0, 8, 0, 0, 0, 16'hFFFF, 0, 1'b0);
        tick();
        checks++; if (wr_data !== 32'h2008FFFF) begin failures++; $display("FAIL b2b_first_data got=%h exp=2008FFFF", wr_data); end
        checks++; if (wr_addr !== 32'h00400000) begin failures++; $display("FAIL b2b_first_addr got=%h exp=00400000", wr_addr); end
        set_instr(4, 5, 9, 0, 0, 0, 16'h1234, 0, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (wr_valid !== 1'b1) begin failures++; $display("FAIL b2b_second_valid got=%b exp=1", wr_valid); end
        checks++; if (wr_data !== 32'h3C091234) begin failures++; $display("FAIL b2b_second_data got=%h exp=3C091234", wr_data); end
        checks++; if (wr_addr !== 32'h00400004) begin failures++; $display("FAIL b2b_second_addr got=%h exp=00400004", wr_addr); end
        tick();
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained_valid got=%b exp=0", wr_valid); end
    endtask

    task automatic test_stall();
        do_reset();
        wr_ready = 1'b0;
        set_instr(9, 0, 0, 0, 0, 0, 0, 26'h0100000, 1'b0);
        tick();
        set_instr(2, 3, 4, 0, 0, 0, 16'h00AA, 0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (wr_valid !== 1'b1) begin failures++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", c, wr_valid); end
            checks++; if (wr_data !== 32'h08100000) begin failures++; $display("FAIL stall_data cyc=%0d got=%h exp=08100000", c, wr_data); end
            checks++; if (wr_addr !== 32'h00400000) begin failures++; $display("FAIL stall_addr cyc=%0d got=%h exp=00400000", c, wr_addr); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
            tick();
        end
        wr_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_drain_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (wr_data !== 32'h346400AA) begin failures++; $display("FAIL stall_next_data got=%h exp=346400AA", wr_data); end
        checks++; if (wr_addr !== 32'h00400004) begin failures++; $display("FAIL stall_next_addr got=%h exp=00400004", wr_addr); end
    endtask

    task automatic test_branch();
        do_reset();
        wr_ready = 1'b1;
        set_instr(7, 1, 2, 0, 0, 0, 16'h0003, 26'h0100000, 1'b0);
        tick();
`ifdef BRANCH_RESOLVE_EN
        checks++; if (wr_data !== 32'h1022FFFF) begin failures++; $display("FAIL beq_data got=%h exp=1022FFFF", wr_data); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL beq_err got=%b exp=0", err); end
        set_instr(8, 1, 2, 0, 0, 0, 16'h0003, 26'h0, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (wr_data !== 32'h1422FFFE) begin failures++; $display("FAIL bne_far_data got=%h exp=1422FFFE", wr_data); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL bne_far_err got=%b exp=1", err); end
`else
        checks++; if (wr_data !== 32'h10220003) begin failures++; $display("FAIL beq_data got=%h exp=10220003", wr_data); end
        set_instr(8, 1, 2, 0, 0, 0, 16'h8000, 26'h3FFFFFF, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (wr_data !== 32'h14228000) begin failures++; $display("FAIL bne_data got=%h exp=14228000", wr_data); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL bne_err got=%b exp=0", err); end
`endif
    endtask

    task automatic test_full();
        int accepted = 0;
        int drained = 0;
        do_reset();
        wr_ready = 1'b1;
        set_instr(12, 1, 2, 3, 0, 0, 0, 0, 1'b0);
        tick();
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL illegal_no_word got=%b exp=0", wr_valid); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL illegal_err got=%b exp=1", err); end
        checks++; if (word_count !== 7'd0) begin failures++; $display("FAIL illegal_count got=%0d exp=0", word_count); end
        for (int c = 0; c < 80; c++) begin
            set_instr(3, 1, accepted % 32, 0, 0, 0, accepted, 0, 1'b0);
            #1;
            if (wr_valid && wr_ready) begin
                checks++; if (wr_addr !== BASE + 32'(4 * drained)) begin failures++; $display("FAIL full_addr n=%0d got=%h exp=%h", drained, wr_addr, BASE + 32'(4 * drained)); end
                drained++;
            end
            if (in_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (accepted !== DEPTH) begin failures++; $display("FAIL full_accepted got=%0d exp=%0d", accepted, DEPTH); end
        checks++; if (drained !== DEPTH) begin failures++; $display("FAIL full_drained got=%0d exp=%0d", drained, DEPTH); end
        checks++; if (word_count !== 7'd64) begin failures++; $display("FAIL full_word_count got=%0d exp=64", word_count); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL full_idle_valid got=%b exp=0", wr_valid); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        do_reset();
        wr_ready = 1'b0;
        set_instr(0, 7, 7, 7, 1, 1, 0, 0, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++; if (wr_valid !== 1'b1) begin failures++; $display("FAIL mid_pending got=%b exp=1", wr_valid); end
        reset = 1'b1;
        tick();
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", wr_valid); end
        checks++; if (word_count !== 7'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", word_count); end
        reset = 1'b0;
        wr_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_ready_after got=%b exp=1", in_ready); end
        set_instr(0, 1, 2, 3, 0, 32'h20, 0, 0, 1'b1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++; if (wr_addr !== 32'h00400000) begin failures++; $display("FAIL mid_next_addr got=%h exp=00400000", wr_addr); end
        for (int c = 0; c < 5; c++) begin
            #1;
            if (done === 1'b1) pulses++;
            tick();
        end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL mid_done_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        int          count = 0;
        bit          modelErr = 1'b0;
        bit          illPend = 1'b0;
        bit          expReady, expDone, legal, rerr, drainNow;
        logic [31:0] w;
        do_reset();
        for (int c = 0; c < 160; c++) begin
            in_valid = ($urandom_range(0, 99) < 60);
            wr_ready = ($urandom_range(0, 99) < 70);
            kind     = 4'($urandom_range(0, 15));
            rs       = 5'($urandom);
            rt       = 5'($urandom);
            rd       = 5'($urandom);
            shamt    = 5'($urandom);
            funct    = 6'($urandom);
            imm      = 16'($urandom);
            in_last  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 1)
                target = 26'($urandom);
            else
                target = 26'(32'h0010_0000 + 32'($urandom_range(0, 200)));
            #1;
            expReady = (count < DEPTH) && ((q.size() == 0) || wr_ready);
            drainNow = (q.size() > 0) && wr_ready;
            expDone  = illPend || (drainNow && q[0].last);
            checks++; if (in_ready !== expReady) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", c, in_ready, expReady); end
            checks++; if (wr_valid !== (q.size() > 0)) begin failures++; $display("FAIL rnd_wr_valid cyc=%0d got=%b exp=%b", c, wr_valid, q.size() > 0); end
            checks++; if (done !== expDone) begin failures++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", c, done, expDone); end
            checks++; if (err !== modelErr) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, err, modelErr); end
            checks++; if (word_count !== 7'(count)) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, word_count, count); end
            if (drainNow) begin
                e = q.pop_front();
                checks++; if (wr_addr !== e.a || wr_data !== e.d) begin failures++; $display("FAIL rnd_word cyc=%0d got=%h/%h exp=%h/%h", c, wr_addr, wr_data, e.a, e.d); end
            end
            illPend = 1'b0;
            if (in_valid && expReady) begin
                e.a = BASE + 32'(4 * count);
                model_encode(kind, rs, rt, rd, shamt, funct, imm, target, e.a, legal, w, rerr);
                if (!legal) begin
                    modelErr = 1'b1;
                    illPend  = in_last;
                end else begin
                    e.d    = w;
                    e.last = in_last;
                    q.push_back(e);
                    count++;
                    if (rerr) modelErr = 1'b1;
                end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_r_word();
        test_back_to_back();
        test_stall();
        test_branch();
        test_full();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
